t5_dwbctl: RTL and testbench

//  Data-bus load/store sequencer for the T5 pipeline. Decodes X-stage load/store ops,

---
 rtl/t5_dwbctl_if.sv | 22 ++
 rtl/t5_dwbctl.sv | 127 ++++++++++++
 tb/tb_t5_dwbctl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/t5_dwbctl_if.sv
// Wishbone-classic data-bus bundle between the T5 load/store sequencer and the bus slave.
interface t5_dwbctl_if #(
    parameter int unsigned XLEN = 32
);
    logic            dwb_cyc;
    logic            dwb_stb;
    logic            dwb_wre;
    logic [3:0]      dwb_sel;
    logic [XLEN-1:0] dwb_adr;
    logic [XLEN-1:0] dwb_dto;
    logic            dwb_ack;

    modport master (
        output dwb_cyc, dwb_stb, dwb_wre, dwb_sel, dwb_adr, dwb_dto,
        input  dwb_ack
    );

    modport slave (
        input  dwb_cyc, dwb_stb, dwb_wre, dwb_sel, dwb_adr, dwb_dto,
        output dwb_ack
    );
endinterface

// File: rtl/t5_dwbctl.sv
// T5 data-bus load/store sequencer: one Wishbone-classic cycle per X-stage memory op,
// holding the pipeline (sena) until ack, misalignment or timeout.
module t5_dwbctl #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned TMO  = 16
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic [4:0]      xopc,
    input  logic [2:0]      xfn3,
    input  logic [XLEN-1:0] xalu,
    input  logic [XLEN-1:0] xrs2,
    t5_dwbctl_if.master     dwb,
    output logic [3:0]      xsel,
    output logic            sena,
    output logic            dmis,
    output logic            derr,
    output logic [XLEN-1:0] dfad
);
    localparam int unsigned CW = 8;
    localparam logic [4:0]  OPC_LOAD  = 5'b00000;
    localparam logic [4:0]  OPC_STORE = 5'b01000;

    typedef enum logic [0:0] {IDLE, BUS} state_t;

    state_t          state;
    logic [CW-1:0]   tmo_cnt;
    logic            xmem;
    logic            xst;
    logic            xmis;
    logic            tmo_hit;
    logic [XLEN-1:0] st_data;

    assign xst     = (xopc == OPC_STORE);
    assign xmem    = (xopc == OPC_LOAD) | xst;
    assign tmo_hit = (tmo_cnt == CW'(TMO - 1));

    // Lane decode, misalignment and store-data replication from the live X-stage op
    always_comb begin
        xsel    = 4'h0;
        xmis    = 1'b0;
        st_data = xrs2;
        case (xfn3[1:0])
            2'b00: begin
                xsel    = 4'b0001 << xalu[1:0];
                st_data = {4{xrs2[7:0]}};
            end
            2'b01: begin
                xsel    = xalu[1] ? 4'hC : 4'h3;
                xmis    = xalu[0];
                st_data = {2{xrs2[15:0]}};
            end
            default: begin
                xsel = 4'hF;
                xmis = (xalu[1:0] != 2'b00);
            end
        endcase
        if (!xmem) begin
            xsel = 4'h0;
            xmis = 1'b0;
        end
    end

    // Pipeline enable: free-running in IDLE except while launching a bus cycle
    always_comb begin
        sena = 1'b1;
        case (state)
            IDLE: sena = !xmem || xmis;
            BUS:  sena = dwb.dwb_ack || tmo_hit;
            default: sena = 1'b1;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            dwb.dwb_cyc <= 1'b0;
            dwb.dwb_stb <= 1'b0;
            dwb.dwb_wre <= 1'b0;
            dwb.dwb_sel <= 4'h0;
            dwb.dwb_adr <= '0;
            dwb.dwb_dto <= '0;
            dmis        <= 1'b0;
            derr        <= 1'b0;
            dfad        <= '0;
        end else begin
            dmis <= 1'b0;
            derr <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (xmem && xmis) begin
                        dmis <= 1'b1;
                        dfad <= xalu;
                    end else if (xmem) begin
                        state       <= BUS;
                        dwb.dwb_cyc <= 1'b1;
                        dwb.dwb_stb <= 1'b1;
                        dwb.dwb_wre <= xst;
                        dwb.dwb_sel <= xsel;
                        dwb.dwb_adr <= {xalu[XLEN-1:2], 2'b00};
                        dwb.dwb_dto <= st_data;
                    end
                end
                BUS: begin
                    // Ack takes priority over a simultaneous timeout expiry
                    if (dwb.dwb_ack || tmo_hit) begin
                        state       <= IDLE;
                        tmo_cnt     <= '0;
                        dwb.dwb_cyc <= 1'b0;
                        dwb.dwb_stb <= 1'b0;
                        dwb.dwb_wre <= 1'b0;
                        dwb.dwb_sel <= 4'h0;
                        if (!dwb.dwb_ack) begin
                            derr <= 1'b1;
                            dfad <= dwb.dwb_adr;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_t5_dwbctl.sv
// Directed self-checking bench for t5_dwbctl (TMO=16).
module tb_t5_dwbctl;
    logic        sclk = 1'b0;
    logic        srst;
    logic [4:0]  xopc;
    logic [2:0]  xfn3;
    logic [31:0] xalu;
    logic [31:0] xrs2;
    logic [3:0]  xsel;
    logic        sena;
    logic        dmis;
    logic        derr;
    logic [31:0] dfad;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [4:0] LOAD  = 5'b00000;
    localparam logic [4:0] STORE = 5'b01000;
    localparam logic [4:0] NOMEM = 5'b01100;

    t5_dwbctl_if #(.XLEN(32)) bus ();

    t5_dwbctl #(.XLEN(32), .TMO(16)) dut (
        .sclk(sclk), .srst(srst), .xopc(xopc), .xfn3(xfn3), .xalu(xalu), .xrs2(xrs2),
        .dwb(bus), .xsel(xsel), .sena(sena), .dmis(dmis), .derr(derr), .dfad(dfad)
    );

    always #5 sclk = ~sclk;

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic test_reset();
        srst = 1'b1; xopc = NOMEM; xfn3 = 3'b010; xalu = 32'h0; xrs2 = 32'h0;
        bus.dwb_ack = 1'b1;
        step(); step();
        srst = 1'b0; bus.dwb_ack = 1'b0;
        #1;
        n_chk++; if (bus.dwb_cyc !== 1'b0 || bus.dwb_stb !== 1'b0 || bus.dwb_wre !== 1'b0) begin n_fail++; $display("FAIL reset_ctl cyc=%b stb=%b wre=%b want 000", bus.dwb_cyc, bus.dwb_stb, bus.dwb_wre); end
        n_chk++; if (bus.dwb_sel !== 4'h0 || bus.dwb_adr !== 32'h0 || bus.dwb_dto !== 32'h0) begin n_fail++; $display("FAIL reset_bus sel=%h adr=%h dto=%h want 0", bus.dwb_sel, bus.dwb_adr, bus.dwb_dto); end
        n_chk++; if (dmis !== 1'b0 || derr !== 1'b0 || dfad !== 32'h0) begin n_fail++; $display("FAIL reset_flags dmis=%b derr=%b dfad=%h want 0", dmis, derr, dfad); end
        n_chk++; if (sena !== 1'b1 || xsel !== 4'h0) begin n_fail++; $display("FAIL reset_idle sena=%b xsel=%h want 1/0", sena, xsel); end
    endtask

    task automatic test_load_wait();
        xopc = LOAD; xfn3 = 3'b010; xalu = 32'h0000_0100; bus.dwb_ack = 1'b0;
        #1;
        n_chk++; if (sena !== 1'b0 || xsel !== 4'hF) begin n_fail++; $display("FAIL lw_launch sena=%b xsel=%h want 0/F", sena, xsel); end
        step();
        n_chk++; if (bus.dwb_cyc !== 1'b1 || bus.dwb_stb !== 1'b1 || bus.dwb_wre !== 1'b0) begin n_fail++; $display("FAIL lw_ctl cyc=%b stb=%b wre=%b want 110", bus.dwb_cyc, bus.dwb_stb, bus.dwb_wre); end
        n_chk++; if (bus.dwb_adr !== 32'h100 || bus.dwb_sel !== 4'hF) begin n_fail++; $display("FAIL lw_adr adr=%h sel=%h want 100/F", bus.dwb_adr, bus.dwb_sel); end
        n_chk++; if (sena !== 1'b0) begin n_fail++; $display("FAIL lw_stall2 sena=%b want 0", sena); end
        step();
        n_chk++; if (sena !== 1'b0 || bus.dwb_cyc !== 1'b1) begin n_fail++; $display("FAIL lw_stall3 sena=%b cyc=%b want 0/1", sena, bus.dwb_cyc); end
        step();
        bus.dwb_ack = 1'b1;
        #1;
        n_chk++; if (sena !== 1'b1) begin n_fail++; $display("FAIL lw_ack_sena sena=%b want 1", sena); end
        step();
        bus.dwb_ack = 1'b0; xopc = NOMEM;
        #1;
        n_chk++; if (bus.dwb_cyc !== 1'b0 || bus.dwb_stb !== 1'b0 || bus.dwb_sel !== 4'h0 || sena !== 1'b1) begin n_fail++; $display("FAIL lw_done cyc=%b stb=%b sel=%h sena=%b want 0 0 0 1", bus.dwb_cyc, bus.dwb_stb, bus.dwb_sel, sena); end
    endtask

    task automatic test_store_byte();
        xopc = STORE; xfn3 = 3'b000; xalu = 32'h0000_0203; xrs2 = 32'h0000_00A5;
        #1;
        n_chk++; if (sena !== 1'b0 || xsel !== 4'h8) begin n_fail++; $display("FAIL sb_launch sena=%b xsel=%h want 0/8", sena, xsel); end
        step();
        n_chk++; if (bus.dwb_wre !== 1'b1 || bus.dwb_sel !== 4'h8 || bus.dwb_dto !== 32'hA5A5_A5A5 || bus.dwb_adr !== 32'h200) begin n_fail++; $display("FAIL sb_bus wre=%b sel=%h dto=%h adr=%h want 1 8 a5a5a5a5 200", bus.dwb_wre, bus.dwb_sel, bus.dwb_dto, bus.dwb_adr); end
        bus.dwb_ack = 1'b1;
        #1;
        n_chk++; if (sena !== 1'b1) begin n_fail++; $display("FAIL sb_ack_sena sena=%b want 1", sena); end
        step();
        bus.dwb_ack = 1'b0; xopc = NOMEM;
        #1;
        n_chk++; if (bus.dwb_cyc !== 1'b0 || bus.dwb_wre !== 1'b0) begin n_fail++; $display("FAIL sb_done cyc=%b wre=%b want 0/0", bus.dwb_cyc, bus.dwb_wre); end
    endtask

    task automatic test_misaligned();
        xopc = LOAD; xfn3 = 3'b001; xalu = 32'h0000_0101;
        #1;
        n_chk++; if (sena !== 1'b1 || xsel !== 4'h3) begin n_fail++; $display("FAIL lh_mis_comb sena=%b xsel=%h want 1/3", sena, xsel); end
        step();
        xopc = NOMEM;
        #1;
        n_chk++; if (dmis !== 1'b1 || dfad !== 32'h101 || bus.dwb_cyc !== 1'b0) begin n_fail++; $display("FAIL lh_mis dmis=%b dfad=%h cyc=%b want 1 101 0", dmis, dfad, bus.dwb_cyc); end
        step();
        n_chk++; if (dmis !== 1'b0) begin n_fail++; $display("FAIL lh_mis_pulse dmis=%b want 0", dmis); end
        // Misaligned word store
        xopc = STORE; xfn3 = 3'b010; xalu = 32'h0000_0402;
        step();
        xopc = NOMEM;
        #1;
        n_chk++; if (dmis !== 1'b1 || dfad !== 32'h402 || bus.dwb_cyc !== 1'b0) begin n_fail++; $display("FAIL sw_mis dmis=%b dfad=%h cyc=%b want 1 402 0", dmis, dfad, bus.dwb_cyc); end
        step();
    endtask

    task automatic test_timeout();
        int stb_cnt = 0;
        xopc = LOAD; xfn3 = 3'b010; xalu = 32'h0000_0100; bus.dwb_ack = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            if (bus.dwb_stb === 1'b1) stb_cnt++;
            if (i == 15) begin
                xopc = NOMEM;
                #1;
                n_chk++; if (sena !== 1'b1) begin n_fail++; $display("FAIL tmo_sena16 sena=%b want 1", sena); end
            end else if (i == 14) begin
                n_chk++; if (sena !== 1'b0 || derr !== 1'b0) begin n_fail++; $display("FAIL tmo_sena15 sena=%b derr=%b want 0/0", sena, derr); end
            end
            step();
        end
        n_chk++; if (stb_cnt != 16) begin n_fail++; $display("FAIL tmo_stb_len got %0d cycles want 16", stb_cnt); end
        n_chk++; if (derr !== 1'b1 || dfad !== 32'h100 || bus.dwb_cyc !== 1'b0 || bus.dwb_stb !== 1'b0) begin n_fail++; $display("FAIL tmo_err derr=%b dfad=%h cyc=%b stb=%b want 1 100 0 0", derr, dfad, bus.dwb_cyc, bus.dwb_stb); end
        step();
        n_chk++; if (derr !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse derr=%b want 0", derr); end
        // Ack arriving on the final count cycle beats the timeout
        xopc = LOAD; xalu = 32'h0000_0500;
        step();
        for (int i = 0; i < 15; i++) step();
        bus.dwb_ack = 1'b1;
        n_chk++; if (bus.dwb_cyc !== 1'b1) begin n_fail++; $display("FAIL tmo_ack_late cyc=%b want 1", bus.dwb_cyc); end
        step();
        bus.dwb_ack = 1'b0; xopc = NOMEM;
        #1;
        n_chk++; if (derr !== 1'b0 || bus.dwb_cyc !== 1'b0 || dfad !== 32'h100) begin n_fail++; $display("FAIL tmo_ack_wins derr=%b cyc=%b dfad=%h want 0 0 100", derr, bus.dwb_cyc, dfad); end
    endtask

    task automatic test_back_to_back();
        xopc = LOAD; xfn3 = 3'b010; xalu = 32'h0000_0300; bus.dwb_ack = 1'b0;
        step();
        bus.dwb_ack = 1'b1;
        step();
        bus.dwb_ack = 1'b0;
        xopc = STORE; xfn3 = 3'b001; xalu = 32'h0000_0302; xrs2 = 32'hDEAD_1234;
        #1;
        n_chk++; if (bus.dwb_cyc !== 1'b0 || sena !== 1'b0 || xsel !== 4'hC) begin n_fail++; $display("FAIL b2b_gap cyc=%b sena=%b xsel=%h want 0 0 C", bus.dwb_cyc, sena, xsel); end
        step();
        n_chk++; if (bus.dwb_cyc !== 1'b1 || bus.dwb_sel !== 4'hC || bus.dwb_wre !== 1'b1 || bus.dwb_adr !== 32'h300 || bus.dwb_dto !== 32'h1234_1234) begin n_fail++; $display("FAIL b2b_sh cyc=%b sel=%h wre=%b adr=%h dto=%h want 1 C 1 300 12341234", bus.dwb_cyc, bus.dwb_sel, bus.dwb_wre, bus.dwb_adr, bus.dwb_dto); end
        bus.dwb_ack = 1'b1;
        step();
        bus.dwb_ack = 1'b0; xopc = NOMEM;
        #1;
        n_chk++; if (bus.dwb_cyc !== 1'b0) begin n_fail++; $display("FAIL b2b_done cyc=%b want 0", bus.dwb_cyc); end
    endtask

    task automatic test_reset_mid_bus();
        xopc = LOAD; xfn3 = 3'b010; xalu = 32'h0000_0600; bus.dwb_ack = 1'b0;
        step();
        step();
        srst = 1'b1;
        step();
        n_chk++; if (bus.dwb_cyc !== 1'b0 || bus.dwb_stb !== 1'b0 || derr !== 1'b0) begin n_fail++; $display("FAIL rst_bus cyc=%b stb=%b derr=%b want 000", bus.dwb_cyc, bus.dwb_stb, derr); end
        srst = 1'b0; xopc = NOMEM; bus.dwb_ack = 1'b1;
        step();
        step();
        n_chk++; if (bus.dwb_cyc !== 1'b0 || derr !== 1'b0 || sena !== 1'b1 || dfad !== 32'h0) begin n_fail++; $display("FAIL rst_ack_ignored cyc=%b derr=%b sena=%b dfad=%h want 0 0 1 0", bus.dwb_cyc, derr, sena, dfad); end
        bus.dwb_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_wait();
        test_store_byte();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid_bus();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
